seven_segment_scan: RTL and testbench

- Downstream display stage: time-multiplexes four BCD digits onto one shared 7-segment bus with per-digit enables, for a 4-digit common-segment display.
- Takes a packed 4-digit BCD value from the seconds/minutes counting logic, decodes each digit internally and scans the digits in turn.
- Inserts a dead-time blank between digits to suppress ghosting.
- Double-buffered input so a counter update never tears a frame.

---
 rtl/seven_segment_scan.sv | 94 +++++++++
 tb/tb_seven_segment_scan.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan.sv
// seven_segment_scan: time-multiplexes four BCD digits onto a shared 7-segment bus with dead-time blanking
//   clk          system clock
//   reset        synchronous active-high reset
//   digits_in    packed BCD, [3:0] = digit 0 (rightmost) .. [15:12] = digit 3
//   load         strobe capturing digits_in into the shadow register
//   blank_mask   per-digit forced blank, sampled when a digit enters DISPLAY
//   led_out      segments, bit0=top .. bit6=middle, active high
//   digit_en     one-hot digit enable, active high
//   frame_start  one-cycle pulse when digit 0 enters DISPLAY
// Optional macro LEADING_ZERO_BLANK_EN: suppress leading zero digits 3..1.
module seven_segment_scan #(
  parameter int SCAN_DIV     = 16000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits_in,
  input  logic        load,
  input  logic [3:0]  blank_mask,
  output logic [6:0]  led_out,
  output logic [3:0]  digit_en,
  output logic        frame_start
);
  localparam int CW = $clog2((SCAN_DIV > BLANK_CYCLES ? SCAN_DIV : BLANK_CYCLES) + 1);
  localparam logic [CW-1:0] S_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] B_LAST = CW'(BLANK_CYCLES - 1);
  typedef enum logic {BLANK, DISPLAY} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   shadow, active, cur;
  logic [3:0]    nib, lz;
  logic [6:0]    seg;
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'b0111111;
      4'd1:    decode = 7'b0000110;
      4'd2:    decode = 7'b1011011;
      4'd3:    decode = 7'b1001111;
      4'd4:    decode = 7'b1100110;
      4'd5:    decode = 7'b1101101;
      4'd6:    decode = 7'b1111100;
      4'd7:    decode = 7'b0000111;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1100111;
      default: decode = 7'b0000000;
    endcase
  endfunction
  // Entering digit 0 latches shadow into active on the same edge, so decode from shadow there.
  always_comb begin
    cur = (idx == 2'd0) ? shadow : active;
    nib = cur[{idx, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    lz[3] = cur[15:12] == 4'd0;
    lz[2] = lz[3] && cur[11:8] == 4'd0;
    lz[1] = lz[2] && cur[7:4] == 4'd0;
    lz[0] = 1'b0;
`else
    lz = 4'b0000;
`endif
    seg = (blank_mask[idx] || lz[idx]) ? 7'd0 : decode(nib);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BLANK;
      cnt         <= '0;
      idx         <= '0;
      shadow      <= '0;
      active      <= '0;
      led_out     <= '0;
      digit_en    <= '0;
      frame_start <= 1'b0;
    end else begin
      if (load) shadow <= digits_in;
      frame_start <= 1'b0;
      if (state == BLANK) begin
        if (cnt == B_LAST) begin
          state       <= DISPLAY;
          cnt         <= '0;
          digit_en    <= 4'b0001 << idx;
          led_out     <= seg;
          frame_start <= idx == 2'd0;
          if (idx == 2'd0) active <= shadow;
        end else cnt <= cnt + 1'b1;
      end else if (cnt == S_LAST) begin
        state    <= BLANK;
        cnt      <= '0;
        idx      <= idx + 1'b1;
        digit_en <= '0;
        led_out  <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_seven_segment_scan.sv
// tb_seven_segment_scan: directed checks of scan order, timing, buffering, decode and blanking
module tb_seven_segment_scan;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits_in = '0;
  logic        load = 1'b0;
  logic [3:0]  blank_mask = '0;
  logic [6:0]  led_out;
  logic [3:0]  digit_en;
  logic        frame_start;
  int total = 0;
  int bad = 0;
  logic [6:0] cap_led [24];
  logic [3:0] cap_en [24];
  logic       cap_fs [24];
  seven_segment_scan #(.SCAN_DIV(4), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .digits_in(digits_in), .load(load), .blank_mask(blank_mask),
    .led_out(led_out), .digit_en(digit_en), .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  task automatic wait_frame(input string name);
    int n = 0;
    while (frame_start !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 100) begin
      bad++;
      $display("FAIL %s frame_start timeout got=%b want=1", name, frame_start);
    end
  endtask
  task automatic capture_frame();
    for (int k = 0; k < 24; k++) begin
      cap_led[k] = led_out;
      cap_en[k] = digit_en;
      cap_fs[k] = frame_start;
      @(negedge clk);
    end
  endtask
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total += 3;
    if (led_out !== 7'd0) begin bad++; $display("FAIL reset_led got=%b want=0", led_out); end
    if (digit_en !== 4'd0) begin bad++; $display("FAIL reset_en got=%b want=0", digit_en); end
    if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs got=%b want=0", frame_start); end
  endtask
  task automatic test_scan();
    logic [6:0] exp [4];
    logic [3:0] e_en;
    logic [6:0] e_led;
    exp = '{7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110};
    reset = 1'b0;
    digits_in = 16'h1234;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    total++;
    if (digit_en !== 4'd0 || frame_start !== 1'b0) begin bad++; $display("FAIL first_blank got en=%b fs=%b want en=0000 fs=0", digit_en, frame_start); end
    @(negedge clk);
    total++;
    if (digit_en !== 4'b0001 || frame_start !== 1'b1) begin bad++; $display("FAIL first_display got en=%b fs=%b want en=0001 fs=1", digit_en, frame_start); end
    capture_frame();
    for (int k = 0; k < 24; k++) begin
      e_en = ((k % 6) < 4) ? 4'b0001 << (k / 6) : 4'b0000;
      e_led = ((k % 6) < 4) ? exp[k / 6] : 7'd0;
      total++;
      if (cap_en[k] !== e_en || cap_led[k] !== e_led || cap_fs[k] !== (k == 0)) begin
        bad++;
        $display("FAIL scan_1234 k=%0d got en=%b led=%b fs=%b want en=%b led=%b fs=%b", k, cap_en[k], cap_led[k], cap_fs[k], e_en, e_led, k == 0);
      end
    end
    total++;
    if (frame_start !== 1'b1) begin bad++; $display("FAIL frame_period got fs=%b want=1", frame_start); end
  endtask
  task automatic test_load_midframe();
    logic [6:0] exp [4];
    logic [3:0] e_en;
    logic [6:0] e_led;
    wait_frame("midframe");
    digits_in = 16'h5678;
    for (int k = 0; k < 24; k++) begin
      cap_led[k] = led_out;
      cap_en[k] = digit_en;
      cap_fs[k] = frame_start;
      load = (k == 13);
      @(negedge clk);
    end
    load = 1'b0;
    exp = '{7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110};
    for (int k = 12; k < 24; k++) begin
      e_en = ((k % 6) < 4) ? 4'b0001 << (k / 6) : 4'b0000;
      e_led = ((k % 6) < 4) ? exp[k / 6] : 7'd0;
      total++;
      if (cap_en[k] !== e_en || cap_led[k] !== e_led) begin
        bad++;
        $display("FAIL torn_frame k=%0d got en=%b led=%b want en=%b led=%b", k, cap_en[k], cap_led[k], e_en, e_led);
      end
    end
    exp = '{7'b1111111, 7'b0000111, 7'b1111100, 7'b1101101};
    capture_frame();
    for (int k = 0; k < 24; k++) begin
      e_en = ((k % 6) < 4) ? 4'b0001 << (k / 6) : 4'b0000;
      e_led = ((k % 6) < 4) ? exp[k / 6] : 7'd0;
      total++;
      if (cap_en[k] !== e_en || cap_led[k] !== e_led || cap_fs[k] !== (k == 0)) begin
        bad++;
        $display("FAIL scan_5678 k=%0d got en=%b led=%b fs=%b want en=%b led=%b fs=%b", k, cap_en[k], cap_led[k], cap_fs[k], e_en, e_led, k == 0);
      end
    end
  endtask
  task automatic test_pattern(input string name, input logic [15:0] val, input logic [3:0] mask,
                              input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] exp [4];
    logic [3:0] e_en;
    logic [6:0] e_led;
    exp = '{s0, s1, s2, s3};
    wait_frame(name);
    digits_in = val;
    blank_mask = mask;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (23) @(negedge clk);
    wait_frame(name);
    capture_frame();
    for (int k = 0; k < 24; k++) begin
      e_en = ((k % 6) < 4) ? 4'b0001 << (k / 6) : 4'b0000;
      e_led = ((k % 6) < 4) ? exp[k / 6] : 7'd0;
      total++;
      if (cap_en[k] !== e_en || cap_led[k] !== e_led || cap_fs[k] !== (k == 0)) begin
        bad++;
        $display("FAIL %s k=%0d got en=%b led=%b fs=%b want en=%b led=%b fs=%b", name, k, cap_en[k], cap_led[k], cap_fs[k], e_en, e_led, k == 0);
      end
    end
  endtask
  task automatic test_reset_midscan();
    wait_frame("reset_mid");
    repeat (7) @(negedge clk);
    total++;
    if (digit_en !== 4'b0010) begin bad++; $display("FAIL pre_reset_digit1 got en=%b want=0010", digit_en); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total += 3;
    if (led_out !== 7'd0) begin bad++; $display("FAIL midreset_led got=%b want=0", led_out); end
    if (digit_en !== 4'd0) begin bad++; $display("FAIL midreset_en got=%b want=0", digit_en); end
    if (frame_start !== 1'b0) begin bad++; $display("FAIL midreset_fs got=%b want=0", frame_start); end
    @(negedge clk);
    total++;
    if (digit_en !== 4'd0 || led_out !== 7'd0) begin bad++; $display("FAIL postreset_blank got en=%b led=%b want 0000 0000000", digit_en, led_out); end
    @(negedge clk);
    total++;
    if (digit_en !== 4'b0001 || led_out !== 7'b0111111 || frame_start !== 1'b1) begin
      bad++;
      $display("FAIL postreset_digit0 got en=%b led=%b fs=%b want en=0001 led=0111111 fs=1", digit_en, led_out, frame_start);
    end
  endtask
  initial begin
    test_reset();
    test_scan();
    test_load_midframe();
    test_pattern("invalid_fa09", 16'hFA09, 4'b0000, 7'b1100111, 7'b0111111, 7'd0, 7'd0);
    test_pattern("mask_8888", 16'h8888, 4'b0101, 7'd0, 7'b1111111, 7'd0, 7'b1111111);
`ifdef LEADING_ZERO_BLANK_EN
    test_pattern("lz_0007", 16'h0007, 4'b0000, 7'b0000111, 7'd0, 7'd0, 7'd0);
    test_pattern("lz_0100", 16'h0100, 4'b0000, 7'b0111111, 7'b0111111, 7'b0000110, 7'd0);
`else
    test_pattern("zeros_0007", 16'h0007, 4'b0000, 7'b0000111, 7'b0111111, 7'b0111111, 7'b0111111);
    test_pattern("zeros_0100", 16'h0100, 4'b0000, 7'b0111111, 7'b0111111, 7'b0000110, 7'b0111111);
`endif
    test_pattern("mask_change", 16'h1234, 4'b1000, 7'b1100110, 7'b1001111, 7'b1011011, 7'd0);
    test_reset_midscan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
